// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the CPU memory controller.
// Holds the control-sequencer one-hot state codes, the memory FSM
// state encoding, the byte-lane select codes and a lane-select helper.
package mem_ctrl_pkg;

  // One-hot pipeline states driven by the control sequencer.
  localparam int CONTROL_BIT_MAX = 4;
  localparam logic [CONTROL_BIT_MAX:0] STATE_FETCH     = 5'b00001;
  localparam logic [CONTROL_BIT_MAX:0] STATE_DECODE    = 5'b00010;
  localparam logic [CONTROL_BIT_MAX:0] STATE_EXECUTE   = 5'b00100;
  localparam logic [CONTROL_BIT_MAX:0] STATE_MEM       = 5'b01000;
  localparam logic [CONTROL_BIT_MAX:0] STATE_WRITEBACK = 5'b10000;

  // Memory controller FSM.
  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUSY = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_t;

  // Byte-lane select codes (bit 0 = low byte, bit 1 = high byte).
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

  // Lane select for an access: word uses both lanes, byte picks by address bit 0.
  function automatic logic [1:0] byte_sel(input logic is_byte, input logic lsb);
    logic [1:0] sel;
    if (!is_byte) begin
      sel = SEL_WORD;
    end else if (lsb) begin
      sel = SEL_HI;
    end else begin
      sel = SEL_LO;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory controller.
// Request side: word-aligned bus address, lane select and store data
// formatting (byte stores replicated on both lanes).
// Response side: selects and zero-extends the addressed byte of a load.
// Ports:
//   req_addr/req_byte/req_store/req_data : access being issued
//   rd_byte/rd_lsb/rd_data               : latched access kind + raw bus data
//   bus_addr/bus_sel/bus_wdata           : formatted bus request fields
//   rd_aligned                           : aligned, zero-extended load data
module mem_lane_align
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_byte,
  input  logic              req_store,
  input  logic [15:0]       req_data,
  input  logic              rd_byte,
  input  logic              rd_lsb,
  input  logic [15:0]       rd_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_sel,
  output logic [15:0]       bus_wdata,
  output logic [15:0]       rd_aligned
);

  // The bus is word addressed; the byte offset is carried by the lane select.
  assign bus_addr = {req_addr[ADDR_W-1:1], 1'b0};
  assign bus_sel  = byte_sel(req_byte, req_addr[0]);

  // Store data: a byte is copied onto both lanes so either lane can take it.
  always_comb begin
    bus_wdata = 16'h0000;
    if (!req_store) begin
      bus_wdata = 16'h0000;
    end else if (req_byte) begin
      bus_wdata = {req_data[7:0], req_data[7:0]};
    end else begin
      bus_wdata = req_data;
    end
  end

  // Load data: pick the addressed lane for byte loads, zero-extended.
  always_comb begin
    rd_aligned = rd_data;
    if (!rd_byte) begin
      rd_aligned = rd_data;
    end else if (rd_lsb) begin
      rd_aligned = {8'h00, rd_data[15:8]};
    end else begin
      rd_aligned = {8'h00, rd_data[7:0]};
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// CPU memory controller: turns FETCH / MEM pipeline states into single
// bus transactions and stalls the sequencer until the bus acknowledges.
// Ports:
//   clk, rst (sync, active-low), en (global enable)
//   control_i  : one-hot sequencer state
//   pc_i, addr_i, data_i, we_i, byte_i : fetch address / load-store request
//   mem_wait_o : stall request (combinational)
//   instr_o, load_o : last fetched word / last load result
//   bus_*      : request/ack bus towards memory
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CONTROL_BIT_MAX:0] control_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [15:0]              data_i,
  input  logic                     we_i,
  input  logic                     byte_i,
  output logic                     mem_wait_o,
  output logic [15:0]              instr_o,
  output logic [15:0]              load_o,
  output logic [ADDR_W-1:0]        bus_addr_o,
  output logic [15:0]              bus_data_o,
  input  logic [15:0]              bus_data_i,
  output logic                     bus_cyc_o,
  output logic                     bus_we_o,
  output logic [1:0]               bus_sel_o,
  input  logic                     bus_ack_i
);

  mem_state_t        state_r;
  mem_state_t        state_nxt_s;
  logic              req_fetch_s;
  logic              req_mem_s;
  logic              start_s;
  logic              complete_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic              req_byte_s;
  logic              req_store_s;
  logic [ADDR_W-1:0] align_addr_s;
  logic [1:0]        align_sel_s;
  logic [15:0]       align_wdata_s;
  logic [15:0]       rd_aligned_s;

  logic              bus_cyc_r;
  logic              bus_we_r;
  logic [1:0]        bus_sel_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [15:0]       bus_data_r;
  logic [15:0]       instr_r;
  logic [15:0]       load_r;
  logic              fetch_r;
  logic              byte_r;
  logic              lsb_r;

  assign req_fetch_s = (control_i == STATE_FETCH);
  assign req_mem_s   = (control_i == STATE_MEM);

  // Fetches are always word reads, so byte/store qualifiers only apply in MEM.
  assign req_addr_s  = req_fetch_s ? pc_i : addr_i;
  assign req_byte_s  = req_mem_s & byte_i;
  assign req_store_s = req_mem_s & we_i;

  // Stall is released only in DONE, giving the sequencer exactly one edge to advance.
  assign mem_wait_o = (req_fetch_s | req_mem_s) & (state_r != MEM_DONE);

  mem_lane_align #(
    .ADDR_W (ADDR_W)
  ) u_lane_align (
    .req_addr   (req_addr_s),
    .req_byte   (req_byte_s),
    .req_store  (req_store_s),
    .req_data   (data_i),
    .rd_byte    (byte_r),
    .rd_lsb     (lsb_r),
    .rd_data    (bus_data_i),
    .bus_addr   (align_addr_s),
    .bus_sel    (align_sel_s),
    .bus_wdata  (align_wdata_s),
    .rd_aligned (rd_aligned_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= MEM_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; ack is honoured in BUSY even with en low.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      MEM_IDLE: begin
        if (en && (req_fetch_s || req_mem_s)) begin
          state_nxt_s = MEM_BUSY;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = MEM_IDLE;
        end
      end
      MEM_BUSY: begin
        if (bus_ack_i) begin
          state_nxt_s = MEM_DONE;
          complete_s  = 1'b1;
        end else begin
          state_nxt_s = MEM_BUSY;
        end
      end
      MEM_DONE: begin
        if (en) begin
          state_nxt_s = MEM_IDLE;
        end else begin
          state_nxt_s = MEM_DONE;
        end
      end
      default: begin
        state_nxt_s = MEM_IDLE;
      end
    endcase
  end

  // Bus request registers and result capture; request fields are frozen for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_cyc_r  <= 1'b0;
      bus_we_r   <= 1'b0;
      bus_sel_r  <= SEL_NONE;
      bus_addr_r <= '0;
      bus_data_r <= 16'h0000;
      instr_r    <= 16'h0000;
      load_r     <= 16'h0000;
      fetch_r    <= 1'b0;
      byte_r     <= 1'b0;
      lsb_r      <= 1'b0;
    end else if (start_s) begin
      bus_cyc_r  <= 1'b1;
      bus_we_r   <= req_store_s;
      bus_sel_r  <= align_sel_s;
      bus_addr_r <= align_addr_s;
      bus_data_r <= align_wdata_s;
      fetch_r    <= req_fetch_s;
      byte_r     <= req_byte_s;
      lsb_r      <= req_addr_s[0];
    end else if (complete_s) begin
      bus_cyc_r <= 1'b0;
      bus_we_r  <= 1'b0;
      if (fetch_r) begin
        instr_r <= bus_data_i;
      end else if (!bus_we_r) begin
        load_r <= rd_aligned_s;
      end
    end
  end

  assign bus_cyc_o  = bus_cyc_r;
  assign bus_we_o   = bus_we_r;
  assign bus_sel_o  = bus_sel_r;
  assign bus_addr_o = bus_addr_r;
  assign bus_data_o = bus_data_r;
  assign instr_o    = instr_r;
  assign load_o     = load_r;

endmodule
